// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage: owns HI/LO, runs MULT/MULTU/DIV/DIVU
// as shift-add / restoring-division loops. Optional macro MULDIV_EARLY_TERM_EN ends multiplies early.
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic [2:0]      ex_op,
    input  logic [XLEN-1:0] ex_a,
    input  logic [XLEN-1:0] ex_b,
    input  logic            mf_req,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            stall,
    output logic            done
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [2*XLEN-1:0] r_acc;
    logic [2*XLEN-1:0] r_opA;
    logic [XLEN-1:0]   r_opB;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [CNT_W-1:0]  r_count;
    logic              r_isDiv;
    logic              r_negRes;
    logic              r_negRem;
    logic              r_divZero;
    logic              r_done;

    logic              w_isMulOp;
    logic              w_isDivOp;
    logic              w_isMoveOp;
    logic              w_signedOp;
    logic              w_stall;
    logic              w_accept;
    logic              w_moveWrite;
    logic [XLEN-1:0]   w_absA;
    logic [XLEN-1:0]   w_absB;
    logic              w_mulLast;
    logic              w_divLast;
    logic [2*XLEN-1:0] w_prodNext;
    logic [XLEN:0]     w_remShift;
    logic [XLEN:0]     w_diff;
    logic              w_qBit;
    logic [XLEN-1:0]   w_remNext;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fixHi;
    logic [XLEN-1:0]   w_fixLo;

    assign w_isMulOp   = (ex_op == OP_MULT) || (ex_op == OP_MULTU);
    assign w_isDivOp   = (ex_op == OP_DIV)  || (ex_op == OP_DIVU);
    assign w_isMoveOp  = (ex_op == OP_MTHI) || (ex_op == OP_MTLO);
    assign w_signedOp  = (ex_op == OP_MULT) || (ex_op == OP_DIV);

    // Any mul/div-related instruction in EX must wait while the unit is occupied.
    assign w_stall     = ex_valid && busy && (mf_req || w_isMulOp || w_isDivOp || w_isMoveOp);
    assign w_accept    = ex_valid && !w_stall && (w_isMulOp || w_isDivOp);
    assign w_moveWrite = ex_valid && !w_stall && w_isMoveOp;

    assign w_absA = (w_signedOp && ex_a[XLEN-1]) ? -ex_a : ex_a;
    assign w_absB = (w_signedOp && ex_b[XLEN-1]) ? -ex_b : ex_b;

    // Multiply: add the left-shifted multiplicand whenever the current multiplier bit is set.
    assign w_prodNext = r_acc + (r_opB[0] ? r_opA : '0);

    // Restoring division: shift the next dividend bit into the partial remainder and trial-subtract.
    assign w_remShift = {r_acc[XLEN-1:0], r_opA[XLEN-1]};
    assign w_diff     = w_remShift - {1'b0, r_opB};
    assign w_qBit     = !w_diff[XLEN];
    assign w_remNext  = w_qBit ? w_diff[XLEN-1:0] : w_remShift[XLEN-1:0];

    assign w_quot = r_opA[XLEN-1:0];
    assign w_rem  = r_acc[XLEN-1:0];

`ifdef MULDIV_EARLY_TERM_EN
    assign w_mulLast = (r_opB[XLEN-1:1] == '0) || (r_count == LAST_ITER);
`else
    assign w_mulLast = (r_count == LAST_ITER);
`endif
    assign w_divLast = r_divZero || (r_count == LAST_ITER);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_nextState = w_isDivOp ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                if (w_mulLast) begin
                    w_nextState = S_FIX;
                end
            end
            S_DIV: begin
                if (w_divLast) begin
                    w_nextState = S_FIX;
                end
            end
            S_FIX: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Datapath: operands are captured on accept, so later EX changes never disturb the loop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc     <= '0;
            r_opA     <= '0;
            r_opB     <= '0;
            r_count   <= '0;
            r_isDiv   <= 1'b0;
            r_negRes  <= 1'b0;
            r_negRem  <= 1'b0;
            r_divZero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc     <= '0;
                        r_opA     <= {{XLEN{1'b0}}, w_absA};
                        r_opB     <= w_absB;
                        r_count   <= '0;
                        r_isDiv   <= w_isDivOp;
                        r_negRes  <= w_signedOp && (ex_a[XLEN-1] ^ ex_b[XLEN-1]);
                        r_negRem  <= (ex_op == OP_DIV) && ex_a[XLEN-1];
                        r_divZero <= w_isDivOp && (ex_b == '0);
                    end
                end
                S_MUL: begin
                    r_acc   <= w_prodNext;
                    r_opA   <= r_opA << 1;
                    r_opB   <= r_opB >> 1;
                    r_count <= r_count + CNT_W'(1);
                end
                S_DIV: begin
                    if (!r_divZero) begin
                        r_acc            <= {{XLEN{1'b0}}, w_remNext};
                        r_opA[XLEN-1:0]  <= {r_opA[XLEN-2:0], w_qBit};
                        r_count          <= r_count + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Sign correction; a zero divisor leaves the untouched |dividend| to restore as HI.
    always_comb begin
        w_fixHi = '0;
        w_fixLo = '0;
        if (r_isDiv) begin
            if (r_divZero) begin
                w_fixHi = r_negRem ? -r_opA[XLEN-1:0] : r_opA[XLEN-1:0];
                w_fixLo = '1;
            end else begin
                w_fixLo = r_negRes ? -w_quot : w_quot;
                w_fixHi = r_negRem ? -w_rem : w_rem;
            end
        end else begin
            {w_fixHi, w_fixLo} = r_negRes ? -r_acc : r_acc;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIX);
            if (r_state == S_FIX) begin
                r_hi <= w_fixHi;
                r_lo <= w_fixLo;
            end else if (w_moveWrite) begin
                if (ex_op == OP_MTHI) begin
                    r_hi <= ex_a;
                end else begin
                    r_lo <= ex_a;
                end
            end
        end
    end

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign busy  = (r_state != S_IDLE);
    assign stall = w_stall;
    assign done  = r_done;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written stall / reset-abort / move sequences.
module tb_ex_muldiv_unit;

    localparam int XLEN = 32;

    logic            clock;
    logic            reset;
    logic            ex_valid;
    logic [2:0]      ex_op;
    logic [XLEN-1:0] ex_a;
    logic [XLEN-1:0] ex_b;
    logic            mf_req;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            busy;
    logic            stall;
    logic            done;

    int checks = 0;
    int passes = 0;

    ex_muldiv_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clock    (clock),
        .reset    (reset),
        .ex_valid (ex_valid),
        .ex_op    (ex_op),
        .ex_a     (ex_a),
        .ex_b     (ex_b),
        .mf_req   (mf_req),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .stall    (stall),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one instruction into EX across a single rising edge, then return #1 after it.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        ex_valid = 1'b1;
        ex_op    = op;
        ex_a     = a;
        ex_b     = b;
        mf_req   = 1'b0;
        @(posedge clock);
        #1;
    endtask

    // Reference model straight from the arithmetic definition of each operation.
    function automatic logic [63:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        int qi;
        int ri;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            3'd1: return sa * sb;
            3'd2: return {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                qi = int'(a) / int'(b);
                ri = int'(a) % int'(b);
                return {32'(ri), 32'(qi)};
            end
            3'd4: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Cycles from the accept edge to the first cycle where done is seen; -1 means divide-by-zero short path.
    function automatic int expLatency(input logic [2:0] op, input logic [31:0] b);
        logic [31:0] mag;
        int bits;
        if (op == 3'd3 || op == 3'd4) begin
            return (b == 32'd0) ? -1 : 33;
        end
        mag = (op == 3'd1 && b[31]) ? -b : b;
        bits = 0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) bits = i + 1;
        end
`ifdef MULDIV_EARLY_TERM_EN
        return ((bits < 1) ? 1 : bits) + 1;
`else
        return 33;
`endif
    endfunction

    // Issue an op, scramble the EX operands while it runs, and measure the latency to done.
    task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int lat;
        int expLat;
        exp = refModel(op, a, b);
        expLat = expLatency(op, b);
        applyStimulus(op, a, b);
        ex_valid = 1'b0;
        ex_op    = 3'd0;
        ex_a     = $urandom;
        ex_b     = $urandom;
        checkOutput({name, "_busy"}, {63'd0, busy}, 64'd1);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) begin
            checkOutput({name, "_done_timeout"}, 64'd0, 64'd1);
        end else begin
            checkOutput({name, "_hilo"}, {hi, lo}, exp);
            if (expLat < 0) begin
                checkOutput({name, "_latency_div0"}, {63'd0, (lat == 1 || lat == 2)}, 64'd1);
            end else begin
                checkOutput({name, "_latency"}, 64'(lat), 64'(expLat));
            end
            @(posedge clock);
            #1;
            checkOutput({name, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
        end
    endtask

    initial begin
        int lat;
        int stallDrops;
        logic sawDone;
        logic [2:0] rop;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0]  = '{"multu_max",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{"mult_neg7x6", 3'd1, 32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFFF, 32'hFFFF_FFD6};
        vecs[2]  = '{"div_neg7_2",  3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{"divu_100_0",  3'd4, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
        vecs[4]  = '{"divu_100_7",  3'd4, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[5]  = '{"div_ovf",     3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[6]  = '{"multu_5x3",   3'd2, 32'd5,         32'd3,         32'd0,         32'd15};
        vecs[7]  = '{"div_7_neg2",  3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[8]  = '{"mult_min_sq", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
        vecs[9]  = '{"mult_max_m1", 3'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
        vecs[10] = '{"div_neg5_0",  3'd3, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[11] = '{"multu_x0",    3'd2, 32'hDEAD_BEEF, 32'd0,         32'd0,         32'd0};

        reset    = 1'b1;
        ex_valid = 1'b0;
        ex_op    = 3'd0;
        ex_a     = '0;
        ex_b     = '0;
        mf_req   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_state", {hi, lo}, 64'd0);
        checkOutput("reset_flags", {61'd0, busy, done, stall}, 64'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Directed table: results are constants worked out by hand.
        for (int i = 0; i < 12; i++) begin
            runOp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b);
            checkOutput({vecs[i].name, "_table"}, {hi, lo}, {vecs[i].expHi, vecs[i].expLo});
        end

        // Randomized ops against the reference model, biased toward zero and short multipliers.
        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(0, 15));
                default: rb = $urandom;
            endcase
            runOp($sformatf("rand%0d", i), rop, ra, rb);
        end

        // MTHI/MTLO while idle: immediate write, no busy, no done.
        applyStimulus(3'd5, 32'h1234_5678, 32'd0);
        ex_valid = 1'b0;
        checkOutput("mthi_hi", {32'd0, hi}, 64'h1234_5678);
        checkOutput("mthi_busy", {63'd0, busy}, 64'd0);
        applyStimulus(3'd6, 32'hCAFE_F00D, 32'd0);
        ex_valid = 1'b0;
        checkOutput("mtlo_lo", {32'd0, lo}, 64'hCAFE_F00D);
        checkOutput("mtlo_flags", {62'd0, busy, done}, 64'd0);

        // MFHI while idle must not stall.
        ex_valid = 1'b1;
        ex_op    = 3'd0;
        mf_req   = 1'b1;
        #1;
        checkOutput("mf_idle_stall", {63'd0, stall}, 64'd0);
        checkOutput("mf_idle_hi", {32'd0, hi}, 64'h1234_5678);
        ex_valid = 1'b0;
        mf_req   = 1'b0;
        @(posedge clock);
        #1;

        // DIVU 100/7 with a dependent MFLO, later a new MULT, waiting in EX.
        applyStimulus(3'd4, 32'd100, 32'd7);
        ex_valid = 1'b1;
        ex_op    = 3'd0;
        mf_req   = 1'b1;
        #1;
        checkOutput("stall_mflo_start", {63'd0, stall}, 64'd1);
        stallDrops = 0;
        sawDone = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock);
            #1;
            if (done) begin
                sawDone = 1'b1;
                break;
            end
            if (!stall) stallDrops++;
            if (c == 16) begin
                mf_req = 1'b0;
                ex_op  = 3'd1;
                ex_a   = 32'hFFFF_FFFF;
                ex_b   = 32'hFFFF_FFFF;
            end
        end
        checkOutput("stall_seq_done", {63'd0, sawDone}, 64'd1);
        checkOutput("stall_held", 64'(stallDrops), 64'd0);
        checkOutput("stall_release", {63'd0, stall}, 64'd0);
        checkOutput("stall_result", {hi, lo}, {32'd2, 32'd14});
        ex_valid = 1'b0;
        ex_op    = 3'd0;
        @(posedge clock);
        #1;

        // Reset in the middle of a MULT aborts it without a HI/LO write or a done pulse.
        applyStimulus(3'd1, 32'h0001_2345, 32'h0006_789A);
        ex_valid = 1'b0;
        ex_op    = 3'd0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        #2;
        checkOutput("abort_hilo", {hi, lo}, 64'd0);
        checkOutput("abort_flags", {62'd0, busy, done}, 64'd0);
        reset = 1'b0;
        sawDone = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (done || busy) sawDone = 1'b1;
        end
        checkOutput("abort_no_done", {63'd0, sawDone}, 64'd0);
        checkOutput("abort_hilo_kept", {hi, lo}, 64'd0);

        // Fresh operation after the abort still works.
        runOp("post_abort", 3'd4, 32'd1000, 32'd33);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
